grant_mux: RTL and testbench

Downstream data stage of the two-agent arbiter: consumes the registered grant lines (`sig_0`/`sig_1`) and moves a fixed-length burst from the granted agent onto one shared valid/ready output port. At the end of each burst it pulses `done_x` so the agent drops its request and the arbiter returns to IDLE. It does not start another burst until the grant is released.

---
 rtl/grant_mux_pkg.sv | 16 +
 rtl/grant_mux_out_stage.sv | 34 +++
 rtl/grant_mux.sv | 117 +++++++++++
 tb/tb_grant_mux.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/grant_mux_pkg.sv
// rtl/grant_mux_pkg.sv - shared state, counter and source encodings for grant_mux
package grant_mux_pkg;

  localparam int CNT_W = 8;

  localparam logic SRC_0 = 1'b0;
  localparam logic SRC_1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    XFER_0   = 2'd1,
    XFER_1   = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

endpackage

// File: rtl/grant_mux_out_stage.sv
// rtl/grant_mux_out_stage.sv - single-entry output register with valid/ready hold
module grant_mux_out_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_src,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic              slot_free
);

  // A new beat may enter when the slot is empty or is being drained this cycle.
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_src   <= load_src;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/grant_mux.sv
// rtl/grant_mux.sv - burst mover from the granted agent to one valid/ready port
// Optional sticky both-grants detection on err: GRANT_MUX_ERR_EN.
module grant_mux
  import grant_mux_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              gnt_0,
  input  logic              gnt_1,
  input  logic              valid_0,
  input  logic              valid_1,
  input  logic [DATA_W-1:0] data_0,
  input  logic [DATA_W-1:0] data_1,
  output logic              ready_0,
  output logic              ready_1,
  output logic              done_0,
  output logic              done_1,
  output logic              abort,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic              err
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             svc;
  logic             slot_free;
  logic             accept;
  logic             last_beat;
  logic             cur_gnt;
  logic [DATA_W-1:0] load_data;
  logic             load_src;

  assign ready_0   = (state == XFER_0) && valid_0 && slot_free;
  assign ready_1   = (state == XFER_1) && valid_1 && slot_free;
  assign accept    = ready_0 || ready_1;
  assign load_data = ready_1 ? data_1 : data_0;
  assign load_src  = ready_1 ? SRC_1 : SRC_0;
  assign last_beat = accept && (cnt == CNT_W'(BURST_LEN - 1));
  assign cur_gnt   = (svc == SRC_1) ? gnt_1 : gnt_0;

  grant_mux_out_stage #(
    .DATA_W(DATA_W)
  ) u_out_stage (
    .clk      (clk),
    .rst      (rest),
    .load     (accept),
    .load_data(load_data),
    .load_src (load_src),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_src  (out_src),
    .slot_free(slot_free)
  );

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state  <= IDLE;
      cnt    <= '0;
      svc    <= SRC_0;
      done_0 <= 1'b0;
      done_1 <= 1'b0;
      abort  <= 1'b0;
    end else begin
      done_0 <= 1'b0;
      done_1 <= 1'b0;
      abort  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (gnt_0) begin
            state <= XFER_0;
            svc   <= SRC_0;
          end else if (gnt_1) begin
            state <= XFER_1;
            svc   <= SRC_1;
          end
        end
        XFER_0, XFER_1: begin
          // Final-beat acceptance wins over a simultaneous grant drop.
          if (last_beat) begin
            state  <= WAIT_REL;
            cnt    <= cnt + CNT_W'(1);
            done_0 <= (svc == SRC_0);
            done_1 <= (svc == SRC_1);
          end else if (!cur_gnt) begin
            state <= IDLE;
            cnt   <= '0;
            abort <= 1'b1;
          end else if (accept) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_REL: begin
          if (!cur_gnt) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GRANT_MUX_ERR_EN
  always_ff @(posedge clk or posedge rest) begin
    if (rest)                err <= 1'b0;
    else if (gnt_0 && gnt_1) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_grant_mux.sv
// tb/tb_grant_mux.sv - table-driven check of grant_mux bursts, stalls, aborts and reset
module tb_grant_mux;

  logic       clk = 1'b0;
  logic       rest;
  logic       gnt_0, gnt_1, valid_0, valid_1;
  logic [7:0] data_0, data_1;
  logic       ready_0, ready_1, done_0, done_1, abort;
  logic       out_valid, out_src, out_ready, err;
  logic [7:0] out_data;

  int passed = 0;
  int total  = 0;

`ifdef GRANT_MUX_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  grant_mux #(.DATA_W(8), .BURST_LEN(4)) dut (
    .clk(clk), .rest(rest),
    .gnt_0(gnt_0), .gnt_1(gnt_1),
    .valid_0(valid_0), .valid_1(valid_1),
    .data_0(data_0), .data_1(data_1),
    .ready_0(ready_0), .ready_1(ready_1),
    .done_0(done_0), .done_1(done_1), .abort(abort),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       g0, g1, v0, v1;
    logic [7:0] d0, d1;
    logic       ordy;
    logic       r0, r1, ov;
    logic [7:0] od;
    logic       os, dn0, dn1, ab;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic g0, g1, v0, v1, input logic [7:0] d0, d1, input logic ordy,
                     input logic r0, r1, ov, input logic [7:0] od, input logic os, dn0, dn1, ab);
    vec_t v;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.d0 = d0; v.d1 = d1; v.ordy = ordy;
    v.r0 = r0; v.r1 = r1; v.ov = ov; v.od = od; v.os = os; v.dn0 = dn0; v.dn1 = dn1; v.ab = ab;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: actual %h required %h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic g0, g1, v0, v1, input logic [7:0] d0, d1, input logic ordy);
    gnt_0 = g0; gnt_1 = g1; valid_0 = v0; valid_1 = v1;
    data_0 = d0; data_1 = d1; out_ready = ordy;
  endtask

  initial begin
    rest = 1'b1;
    drive(0, 0, 0, 0, 8'h00, 8'h00, 1'b0);
    #2;
    chk("reset_outputs", {ready_0, ready_1, done_0, done_1, abort, out_valid, out_src, out_data, err}, '0);
    @(negedge clk);
    rest = 1'b0;

    // basic burst agent 0
    add(1,0,1,0,8'h10,0,1, 0,0,0,8'h00,0,0,0,0);
    add(1,0,1,0,8'h10,0,1, 1,0,0,8'h00,0,0,0,0);
    add(1,0,1,0,8'h11,0,1, 1,0,1,8'h10,0,0,0,0);
    add(1,0,1,0,8'h12,0,1, 1,0,1,8'h11,0,0,0,0);
    add(1,0,1,0,8'h13,0,1, 1,0,1,8'h12,0,0,0,0);
    add(1,0,1,0,8'h14,0,1, 0,0,1,8'h13,0,1,0,0);
    add(1,0,1,0,8'h14,0,1, 0,0,0,8'h00,0,0,0,0);
    add(0,0,1,0,8'h14,0,1, 0,0,0,8'h00,0,0,0,0);
    add(0,0,0,0,8'h00,0,1, 0,0,0,8'h00,0,0,0,0);
    // backpressure agent 1
    add(0,1,0,1,0,8'hA0,1, 0,0,0,8'h00,0,0,0,0);
    add(0,1,0,1,0,8'hA0,1, 0,1,0,8'h00,0,0,0,0);
    add(0,1,0,1,0,8'hA1,1, 0,1,1,8'hA0,1,0,0,0);
    add(0,1,0,1,0,8'hA2,0, 0,0,1,8'hA1,1,0,0,0);
    add(0,1,0,1,0,8'hA2,0, 0,0,1,8'hA1,1,0,0,0);
    add(0,1,0,1,0,8'hA2,0, 0,0,1,8'hA1,1,0,0,0);
    add(0,1,0,1,0,8'hA2,1, 0,1,1,8'hA1,1,0,0,0);
    add(0,1,0,1,0,8'hA3,1, 0,1,1,8'hA2,1,0,0,0);
    add(0,0,0,0,0,8'h00,1, 0,0,1,8'hA3,1,0,1,0);
    add(0,0,0,0,0,8'h00,1, 0,0,0,8'h00,0,0,0,0);
    // abort after two beats
    add(1,0,1,0,8'h20,0,1, 0,0,0,8'h00,0,0,0,0);
    add(1,0,1,0,8'h20,0,1, 1,0,0,8'h00,0,0,0,0);
    add(1,0,1,0,8'h21,0,1, 1,0,1,8'h20,0,0,0,0);
    add(0,0,0,0,8'h00,0,1, 0,0,1,8'h21,0,0,0,0);
    add(0,0,0,0,8'h00,0,1, 0,0,0,8'h00,0,0,0,1);
    // fresh grant counts from zero, then release gating
    add(1,0,1,0,8'h30,0,1, 0,0,0,8'h00,0,0,0,0);
    add(1,0,1,0,8'h30,0,1, 1,0,0,8'h00,0,0,0,0);
    add(1,0,1,0,8'h31,0,1, 1,0,1,8'h30,0,0,0,0);
    add(1,0,1,0,8'h32,0,1, 1,0,1,8'h31,0,0,0,0);
    add(1,0,1,0,8'h33,0,1, 1,0,1,8'h32,0,0,0,0);
    add(1,0,1,0,8'h34,0,1, 0,0,1,8'h33,0,1,0,0);
    add(1,0,1,0,8'h34,0,1, 0,0,0,8'h00,0,0,0,0);
    add(1,0,1,0,8'h34,0,1, 0,0,0,8'h00,0,0,0,0);
    add(1,0,1,0,8'h34,0,1, 0,0,0,8'h00,0,0,0,0);
    add(1,0,1,0,8'h34,0,1, 0,0,0,8'h00,0,0,0,0);
    add(0,0,1,0,8'h34,0,1, 0,0,0,8'h00,0,0,0,0);
    add(1,0,1,0,8'h40,0,1, 0,0,0,8'h00,0,0,0,0);
    add(1,0,1,0,8'h40,0,1, 1,0,0,8'h00,0,0,0,0);
    add(0,0,0,0,8'h00,0,1, 0,0,1,8'h40,0,0,0,0);
    add(0,0,0,0,8'h00,0,1, 0,0,0,8'h00,0,0,0,1);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      logic [14:0] act, exp;
      v = vecs[i];
      @(negedge clk);
      drive(v.g0, v.g1, v.v0, v.v1, v.d0, v.d1, v.ordy);
      #1;
      act = {ready_0, ready_1, out_valid, v.ov ? out_data : 8'h00, v.ov ? out_src : 1'b0,
             done_0, done_1, abort};
      exp = {v.r0, v.r1, v.ov, v.od, v.os, v.dn0, v.dn1, v.ab};
      chk($sformatf("vec%0d", i), 64'(act), 64'(exp));
    end

    // both grants: agent 0 wins, err follows the build option
    @(negedge clk);
    drive(1, 1, 1, 1, 8'h55, 8'h66, 1'b1);
    #1;
    chk("err_before_edge", 64'(err), 64'(1'b0));
    @(negedge clk);
    #1;
    chk("both_gnt_ready", 64'({ready_0, ready_1, err}), 64'({1'b1, 1'b0, ERR_EN}));
    @(negedge clk);
    drive(0, 0, 0, 0, 8'h00, 8'h00, 1'b1);
    #1;
    chk("both_gnt_out", 64'({out_valid, out_src, out_data}), 64'({1'b1, 1'b0, 8'h55}));
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("err_sticky", 64'({err, abort}), 64'({ERR_EN, 1'b0}));

    // asynchronous reset mid-burst with a buffered beat
    @(negedge clk);
    drive(0, 1, 0, 1, 8'h00, 8'h77, 1'b0);
    @(negedge clk);
    #1;
    chk("pre_reset_ready", 64'(ready_1), 64'(1'b1));
    @(negedge clk);
    #1;
    chk("pre_reset_buffered", 64'({out_valid, out_data}), 64'({1'b1, 8'h77}));
    #1;
    rest = 1'b1;
    #1;
    chk("mid_reset_outputs", {ready_0, ready_1, done_0, done_1, abort, out_valid, out_src, out_data, err}, '0);
    @(negedge clk);
    rest = 1'b0;
    drive(0, 1, 0, 1, 8'h00, 8'h80, 1'b1);
    for (int i = 0; i < 5; i++) begin
      logic [7:0] dv;
      @(negedge clk);
      dv = 8'h80 + 8'(i);
      data_1 = dv;
      #1;
      chk($sformatf("post_reset_%0d", i),
          64'({ready_1, done_1, out_valid, (i >= 1) ? out_data : 8'h00}),
          64'({(i < 4), (i == 4), (i >= 1), (i >= 1) ? 8'(dv - 8'h01) : 8'h00}));
    end
    drive(0, 0, 0, 0, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    #1;
    chk("post_reset_err", 64'({err, abort}), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
